// File: rtl/div_nxn_seq_if.sv
// rtl/div_nxn_seq_if.sv - request/result bundle for the sequential NxN divider
interface div_nxn_seq_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;

    // Requester drives operands and start, observes status and results
    modport master (
        output start, a, b,
        input  busy, done, q, r, dbz
    );

    // Divider consumes operands and start, drives status and results
    modport slave (
        input  start, a, b,
        output busy, done, q, r, dbz
    );
endinterface

// File: rtl/div_nxn_seq.sv
// rtl/div_nxn_seq.sv - sequential unsigned NxN restoring divider, one quotient bit per clock
module div_nxn_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    div_nxn_seq_if.slave bus
);
    // Counter is one bit wider than needed so N-1 always fits
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [N-1:0]  r_dvd;
    logic [N-1:0]  r_dvs;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_quot;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_r;
    logic          r_dbz;

    logic          w_accept;
    logic          w_div_zero;
    logic [N:0]    w_rem_shift;
    logic          w_ge;
    logic [N:0]    w_rem_next;
    logic [N:0]    w_quot_shift;
    logic [N-1:0]  w_quot_next;
    logic          w_last;

    // A new request is only taken when not iterating
    assign w_accept   = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_div_zero = (bus.b == '0);

    // One restoring step: shift next dividend bit into the N+1 bit remainder, trial subtract
    assign w_rem_shift  = {r_rem[N-1:0], r_dvd[N-1]};
    assign w_ge         = (w_rem_shift >= {1'b0, r_dvs});
    assign w_rem_next   = w_ge ? (w_rem_shift - {1'b0, r_dvs}) : w_rem_shift;
    assign w_quot_shift = {r_quot, w_ge};
    assign w_quot_next  = w_quot_shift[N-1:0];
    assign w_last       = (r_cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: zero divisor short-circuits straight to DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = w_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_state_next = w_div_zero ? DONE : RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_dvd  <= bus.a;
            r_dvs  <= bus.b;
            r_rem  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            if (w_div_zero) begin
                r_q   <= '1;
                r_r   <= bus.a;
                r_dbz <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_dvd  <= {r_dvd[N-2:0], 1'b0};
            r_rem  <= w_rem_next;
            r_quot <= w_quot_next;
            r_cnt  <= r_cnt + CW'(1);
            // Final step publishes directly; remainder is < divisor so the top bit is zero
            if (w_last) begin
                r_q   <= w_quot_next;
                r_r   <= w_rem_next[N-1:0];
                r_dbz <= 1'b0;
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.dbz  = r_dbz;

endmodule

// File: tb/tb_div_nxn_seq.sv
// tb/tb_div_nxn_seq.sv - directed self-checking bench for div_nxn_seq
module tb_div_nxn_seq;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n_overlap;

    div_nxn_seq_if #(.N(N)) bus_if ();

    div_nxn_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // busy and done must never be seen together
    always @(negedge clk) begin
        if (rst_n && bus_if.busy && bus_if.done) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its done strobe
    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                          output logic [3:0] oq, output logic [3:0] orr,
                          output logic odbz, output int busy_n, output int lat);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = ia;
        bus_if.b     = ib;
        @(negedge clk);
        bus_if.start = 1'b0;
        lat    = 0;
        busy_n = 0;
        oq     = '0;
        orr    = '0;
        odbz   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge clk);
            if (bus_if.busy) busy_n++;
            if (bus_if.done) begin
                oq   = bus_if.q;
                orr  = bus_if.r;
                odbz = bus_if.dbz;
                lat  = i;
                break;
            end
        end
    endtask

    logic [3:0] q, r;
    logic       dbz;
    int         bn, lat, dones, gap;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        n_overlap = 0;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;

        // Reset with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_if.start = 1'($urandom_range(0, 1));
            bus_if.a     = 4'($urandom_range(0, 15));
            bus_if.b     = 4'($urandom_range(0, 15));
        end
        bus_if.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_q",    32'(bus_if.q),    32'd0);
        check("rst_r",    32'(bus_if.r),    32'd0);
        check("rst_dbz",  32'(bus_if.dbz),  32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);

        // Basic divisions
        run_op(4'd13, 4'd3, q, r, dbz, bn, lat);
        check("13/3_lat",  32'(lat), 32'd5);
        check("13/3_busy", 32'(bn),  32'd4);
        check("13/3_q",    32'(q),   32'd4);
        check("13/3_r",    32'(r),   32'd1);
        check("13/3_dbz",  32'(dbz), 32'd0);
        @(negedge clk);
        check("13/3_done_1cyc", 32'(bus_if.done), 32'd0);

        run_op(4'd15, 4'd1, q, r, dbz, bn, lat);
        check("15/1_q", 32'(q), 32'd15);
        check("15/1_r", 32'(r), 32'd0);

        run_op(4'd7, 4'd15, q, r, dbz, bn, lat);
        check("7/15_q", 32'(q), 32'd0);
        check("7/15_r", 32'(r), 32'd7);

        // Divide by zero
        run_op(4'd9, 4'd0, q, r, dbz, bn, lat);
        check("9/0_lat",  32'(lat), 32'd1);
        check("9/0_busy", 32'(bn),  32'd0);
        check("9/0_q",    32'(q),   32'd15);
        check("9/0_r",    32'(r),   32'd9);
        check("9/0_dbz",  32'(dbz), 32'd1);

        run_op(4'd8, 4'd2, q, r, dbz, bn, lat);
        check("8/2_q",   32'(q),   32'd4);
        check("8/2_r",   32'(r),   32'd0);
        check("8/2_dbz", 32'(dbz), 32'd0);

        // Start during RUN and operand changes are ignored
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = 4'd13;
        bus_if.b     = 4'd3;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = 4'd6;
        bus_if.b     = 4'd2;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.a     = 4'd9;
        bus_if.b     = 4'd7;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus_if.done) begin
                if (dones == 0) begin
                    q = bus_if.q;
                    r = bus_if.r;
                end
                dones++;
            end
            @(negedge clk);
        end
        check("ign_dones", 32'(dones), 32'd1);
        check("ign_q",     32'(q),     32'd4);
        check("ign_r",     32'(r),     32'd1);

        // Back-to-back with start held high
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = 4'd12;
        bus_if.b     = 4'd5;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus_if.done) begin
                q   = bus_if.q;
                r   = bus_if.r;
                lat = i;
                break;
            end
        end
        check("b2b1_seen", 32'(lat != 0), 32'd1);
        check("b2b1_q",    32'(q),        32'd2);
        check("b2b1_r",    32'(r),        32'd2);
        bus_if.a = 4'd14;
        bus_if.b = 4'd4;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("b2b_done_drop", 32'(bus_if.done), 32'd0);
        check("b2b_busy_rise", 32'(bus_if.busy), 32'd1);
        gap = 0;
        for (int j = 2; j <= 20; j++) begin
            @(negedge clk);
            if (bus_if.done) begin
                q   = bus_if.q;
                r   = bus_if.r;
                gap = j;
                break;
            end
        end
        check("b2b_gap", 32'(gap), 32'd5);
        check("b2b2_q",  32'(q),   32'd3);
        check("b2b2_r",  32'(r),   32'd2);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = 4'd13;
        bus_if.b     = 4'd3;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
        check("mid_rst_done", 32'(bus_if.done), 32'd0);
        check("mid_rst_q",    32'(bus_if.q),    32'd0);
        check("mid_rst_r",    32'(bus_if.r),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.done) dones++;
        end
        check("mid_rst_nodone", 32'(dones), 32'd0);
        run_op(4'd10, 4'd3, q, r, dbz, bn, lat);
        check("10/3_q", 32'(q), 32'd3);
        check("10/3_r", 32'(r), 32'd1);

        // Exhaustive sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_op(4'(ia), 4'(ib), q, r, dbz, bn, lat);
                if (ib == 0) begin
                    check("sw0_q",   32'(q),   32'd15);
                    check("sw0_r",   32'(r),   32'(ia));
                    check("sw0_dbz", 32'(dbz), 32'd1);
                end else begin
                    check("sw_qbr",  32'(q) * 32'(ib) + 32'(r), 32'(ia));
                    check("sw_rltb", 32'(32'(r) < 32'(ib)),     32'd1);
                    check("sw_dbz",  32'(dbz), 32'd0);
                    check("sw_lat",  32'(lat), 32'd5);
                end
            end
        end

        check("busy_done_overlap", 32'(n_overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
